// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and the field width common to
// the PWM generator and the PWM capture block.
package pwm_pkg;
   localparam int PWM_CW         = 8;
   localparam int PWM_MAX_PERIOD = 2 ** PWM_CW;

   typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;
endpackage

// File: rtl/pwm_capture_if.sv
// Result bus of the PWM capture block: captured word, update strobe and
// lock/stuck status.
interface pwm_capture_if import pwm_pkg::*; #(parameter int CW = PWM_CW) ();
   logic [2*CW-1:0] pwm_word;
   logic            valid;
   logic            locked;
   logic            stuck;
   logic            stuck_level;

   modport master (output pwm_word, valid, locked, stuck, stuck_level);
   modport slave  (input  pwm_word, valid, locked, stuck, stuck_level);
endinterface

// File: rtl/pwm_in_sync.sv
// Two-flop synchroniser for the asynchronous PWM input plus a history flop
// for rising-edge detection.
module pwm_in_sync import pwm_pkg::*; (
   input  logic clk,
   input  logic reset,
   input  logic pwm_in,
   output logic s2,
   output logic rise
);
   logic s1;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= pwm_in;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign rise = s2 & ~prev;
endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures period and high time of pwm_in in clk cycles and
// reports them in the generator's {period-1, duty} word format.
module pwm_capture import pwm_pkg::*; #(
   parameter int CW = PWM_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pwm_in,
   pwm_capture_if.master bus
);
   localparam logic [CW:0] MAXP = {1'b1, {CW{1'b0}}};
   localparam logic [CW:0] ONE  = {{CW{1'b0}}, 1'b1};

   state_t      state;
   logic [CW:0] pcnt;
   logic [CW:0] hcnt;
   logic        s2;
   logic        rise;

   pwm_in_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .pwm_in (pwm_in),
      .s2     (s2),
      .rise   (rise)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         pcnt            <= '0;
         hcnt            <= '0;
         bus.pwm_word    <= '0;
         bus.valid       <= 1'b0;
         bus.locked      <= 1'b0;
         bus.stuck       <= 1'b0;
         bus.stuck_level <= 1'b0;
      end else begin
         bus.valid <= 1'b0;

         // Both counters include the rise cycle itself, so at the next rise
         // they hold exactly P and H; saturation keeps them parked at 2^CW.
         if (rise) begin
            pcnt <= ONE;
            hcnt <= ONE;
         end else begin
            if (pcnt != MAXP) pcnt <= pcnt + ONE;
            if (hcnt != MAXP) hcnt <= hcnt + {{CW{1'b0}}, s2};
         end

         case (state)
            IDLE: begin
               if (rise) state <= MEASURE;
            end
            MEASURE: begin
               if (rise) begin
                  bus.pwm_word <= {pcnt[CW-1:0] - CW'(1), hcnt[CW-1:0] - CW'(1)};
                  bus.valid    <= 1'b1;
                  bus.locked   <= 1'b1;
               end else if (pcnt == MAXP) begin
                  state           <= TIMEOUT;
                  bus.stuck       <= 1'b1;
                  bus.locked      <= 1'b0;
                  bus.stuck_level <= s2;
               end
            end
            TIMEOUT: begin
               if (rise) begin
                  bus.stuck <= 1'b0;
                  state     <= MEASURE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- PWM decoder: the receive-side counterpart of the team's PWM generator.
- Samples an asynchronous PWM waveform and measures its period and high time in clk cycles.
- Reports both in the same packed {period-1, duty} encoding the generator consumes, so a captured word fed to the generator reproduces the waveform.
- Used for loopback self-test of the synth PWM audio path and for decoding external PWM control inputs.

Parameters:
- CW, 8, width of each field (period_m1, duty); the longest measurable period is 2^CW cycles.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM waveform; single-bit, glitch-free source.
- pwm_word  output  2*CW  captured word: [2CW-1:CW] = period-1, [CW-1:0] = high cycles-1.
- valid  output  1  one-cycle pulse when pwm_word updates.
- locked  output  1  high while consecutive rising edges arrive within 2^CW cycles.
- stuck  output  1  high when no rising edge has arrived within 2^CW cycles of the last one.
- stuck_level  output  1  synchronised pwm_in level, registered when stuck rises.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk. All state updates on posedge clk only.
- Reset values: pwm_word=0, valid=0, locked=0, stuck=0, stuck_level=0, state=IDLE, sync flops=0, counters=0.
- Input conditioning: 2-FF synchroniser s1 -> s2, plus a prev register of s2. rise = s2 & ~prev, combinational.
- Counters (CW+1 bits):
  - pcnt: on a rise edge load 1; otherwise pcnt+1, saturating at 2^CW.
  - hcnt: on a rise edge load 1; otherwise hcnt+s2, saturating at 2^CW.
- FSM states IDLE, MEASURE, TIMEOUT:
  - IDLE: wait for rise; load counters; go to MEASURE. No valid output.
  - MEASURE on a rise edge: pwm_word <= {pcnt-1, hcnt-1} (low CW bits of each); valid <= 1; locked <= 1; counters reload; stay in MEASURE.
  - MEASURE without rise, when pcnt == 2^CW: go to TIMEOUT; stuck <= 1; locked <= 0; stuck_level <= s2.
  - TIMEOUT: on rise, clear stuck, load counters, go to MEASURE. Lock returns on the next full period.
- pwm_word holds its last value while in TIMEOUT or IDLE. Only reset clears it.
- Latency: pwm_in sampled high at edge k gives rise during the cycle after edge k+1. The capture registers at edge k+2, so valid is high in the cycle after edge k+2, i.e. 3 edges.
- Period P counts clk cycles between successive rising edges. Duty counts cycles sampled high in that span; always 1..P-1, so it never underflows.
- Boundaries:
  - P = 2^CW: captured, period field = all ones.
  - P = 2^CW+1: TIMEOUT.
  - P = 2 (1 high, 1 low): period field 1, duty 0.
  - Constant high or low: TIMEOUT, stuck_level reports the level.
- Reset mid-measurement: abandons the current period. The first rise after reset only arms the block; the first valid follows the second rise.
- No backpressure: valid is a pulse; consumers must sample it that cycle.

Decomposition:
- Shared package pwm_pkg:
  - state enum {IDLE, MEASURE, TIMEOUT};
  - default field width constant PWM_CW = 8, shared with the generator;
  - helper constant PWM_MAX_PERIOD = 2^PWM_CW.
- Sub-module pwm_in_sync: 2-FF synchroniser + prev register, outputs s2 and rise. Reset clears all three flops.
- Counters and FSM stay in pwm_capture.

Test Plan:
- Generator driven with pwm_reg = 16'h0903 (P=10, high 4) -> first valid after the 2nd rise, pwm_word=16'h0903, locked=1; valid every 10 cycles thereafter.
- Minimum period pwm_reg = 16'h0100 (P=2, high 1) -> pwm_word=16'h0100, valid every 2 cycles.
- Maximum period pwm_reg = 16'hFFFE (P=256, high 255) -> pwm_word=16'hFFFE, stuck stays 0.
- pwm_in held high after a valid period -> 256 cycles after the last rise, stuck=1, stuck_level=1, locked=0, pwm_word unchanged; on the next rise stuck=0; next full period gives valid.
- reset asserted mid-period with P=10 running -> all outputs 0 next cycle; after release, no valid until the 2nd rise, then pwm_word=16'h0903.
- Change generator from 16'h0903 to 16'h1307 at a period boundary -> one valid with 16'h0903, then 16'h1307 on the following period; no intermediate value.
